// File: rtl/raster_pkg.sv
// rtl/raster_pkg.sv - fragment word layout and fraggen state encoding shared with lambdagen
package raster_pkg;

  localparam int FRAG_W    = 128;
  localparam int TID_LSB   = 112;
  localparam int X_LSB     = 96;
  localparam int Y_LSB     = 80;
  localparam int LAST_BIT  = 65;
  localparam int FIRST_BIT = 64;

  typedef struct packed {
    logic [15:0] tid;
    logic [15:0] x;
    logic [15:0] y;
    logic [13:0] rsvd_hi;
    logic        last;
    logic        first;
    logic [63:0] rsvd_lo;
  } frag_word_t;

  typedef enum logic [0:0] {
    FRAG_IDLE = 1'b0,
    FRAG_WALK = 1'b1
  } fraggen_state_e;

  function automatic frag_word_t make_frag(input logic [15:0] tid, input logic [15:0] x,
                                           input logic [15:0] y, input logic first,
                                           input logic last);
    frag_word_t w;
    w       = '0;
    w.tid   = tid;
    w.x     = x;
    w.y     = y;
    w.first = first;
    w.last  = last;
    return w;
  endfunction

endpackage

// File: rtl/fraggen_bbox_clip.sv
// rtl/fraggen_bbox_clip.sv - screen clip and degenerate-box detect (clip under FRAGGEN_CLIP_EN)
module fraggen_bbox_clip #(
  parameter int COORD_W  = 16,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic [COORD_W-1:0] xmin,
  input  logic [COORD_W-1:0] xmax,
  input  logic [COORD_W-1:0] ymin,
  input  logic [COORD_W-1:0] ymax,
  output logic [COORD_W-1:0] xmax_c,
  output logic [COORD_W-1:0] ymax_c,
  output logic               degenerate
);

`ifdef FRAGGEN_CLIP_EN
  localparam logic [COORD_W-1:0] X_LIM = COORD_W'(SCREEN_W - 1);
  localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(SCREEN_H - 1);

  assign xmax_c = (xmax > X_LIM) ? X_LIM : xmax;
  assign ymax_c = (ymax > Y_LIM) ? Y_LIM : ymax;
`else
  logic unused_screen;

  assign xmax_c        = xmax;
  assign ymax_c        = ymax;
  assign unused_screen = (SCREEN_W != SCREEN_H);
`endif

  // Tested after clipping so fully off-screen boxes are dropped too.
  assign degenerate = (xmin > xmax_c) || (ymin > ymax_c);

endmodule

// File: rtl/fraggen.sv
// rtl/fraggen.sv - raster-order fragment walker feeding lambdagen (optional clip: FRAGGEN_CLIP_EN)
module fraggen
  import raster_pkg::*;
#(
  parameter int COORD_W  = 16,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tri_valid,
  output logic               tri_ready,
  input  logic [15:0]        tri_id,
  input  logic [COORD_W-1:0] xmin,
  input  logic [COORD_W-1:0] xmax,
  input  logic [COORD_W-1:0] ymin,
  input  logic [COORD_W-1:0] ymax,
  output logic               valid,
  input  logic               stall,
  output logic [127:0]       input_bus,
  output logic               busy,
  output logic [31:0]        frag_count,
  output logic [15:0]        drop_count
);

  localparam logic [0:0] S_IDLE = FRAG_IDLE;
  localparam logic [0:0] S_WALK = FRAG_WALK;

  logic [0:0]         state;
  logic [COORD_W-1:0] cur_x, cur_y, lo_x, hi_x, hi_y;
  logic [COORD_W-1:0] clip_xmax, clip_ymax, nxt_x, nxt_y;
  logic [15:0]        cur_tid;
  logic               degenerate, accept, consume;
  logic               at_row_end, at_end, first_is_last, next_is_last;
  frag_word_t         word_q;

  fraggen_bbox_clip #(
    .COORD_W  (COORD_W),
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_clip (
    .xmin       (xmin),
    .xmax       (xmax),
    .ymin       (ymin),
    .ymax       (ymax),
    .xmax_c     (clip_xmax),
    .ymax_c     (clip_ymax),
    .degenerate (degenerate)
  );

  assign tri_ready = (state == S_IDLE);
  assign busy      = (state == S_WALK);
  assign accept    = tri_ready && tri_valid;
  assign consume   = valid && !stall;
  assign input_bus = word_q;

  // Next-pixel precompute so the following word is ready on the consume edge.
  assign at_row_end    = (cur_x == hi_x);
  assign at_end        = at_row_end && (cur_y == hi_y);
  assign nxt_x         = at_row_end ? lo_x : cur_x + COORD_W'(1);
  assign nxt_y         = at_row_end ? cur_y + COORD_W'(1) : cur_y;
  assign next_is_last  = (nxt_x == hi_x) && (nxt_y == hi_y);
  assign first_is_last = (xmin == clip_xmax) && (ymin == clip_ymax);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      valid      <= 1'b0;
      word_q     <= '0;
      frag_count <= '0;
      drop_count <= '0;
      cur_x      <= '0;
      cur_y      <= '0;
      lo_x       <= '0;
      hi_x       <= '0;
      hi_y       <= '0;
      cur_tid    <= '0;
    end else begin
      if (consume) frag_count <= frag_count + 32'd1;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (degenerate) begin
              if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            end else begin
              cur_tid <= tri_id;
              lo_x    <= xmin;
              hi_x    <= clip_xmax;
              hi_y    <= clip_ymax;
              cur_x   <= xmin;
              cur_y   <= ymin;
              word_q  <= make_frag(tri_id, 16'(xmin), 16'(ymin), 1'b1, first_is_last);
              valid   <= 1'b1;
              state   <= S_WALK;
            end
          end
        end
        default: begin
          if (consume) begin
            if (at_end) begin
              state  <= S_IDLE;
              valid  <= 1'b0;
              word_q <= '0;
            end else begin
              cur_x  <= nxt_x;
              cur_y  <= nxt_y;
              word_q <= make_frag(cur_tid, 16'(nxt_x), 16'(nxt_y), 1'b0, next_is_last);
            end
          end
        end
      endcase
    end
  end

endmodule
